// File: rtl/mem_arbiter_if.sv
// Bus bundle between the datapath/cache side, the arbiter and the RAM model.
// The slave modport is the arbiter's view; the master modport is the view of
// whatever environment drives requests and plays the RAM.
interface mem_arbiter_if;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        dwait;
    logic [31:0] dload;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic [1:0]  ramstate;
    logic        err;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, err
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, err
    );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between instruction fetch and data access.
// Data requests normally win; after STARVE_MAX back-to-back data completions
// with a fetch waiting, the fetch is granted instead. Every grant passes
// through IDLE, so each access costs at least one arbitration cycle.
module mem_arbiter #(
    parameter int          STARVE_MAX = 4,
    parameter logic [31:0] ERR_WORD   = 32'hBAD1BAD1
) (
    input  logic         CLK,
    input  logic         nRST,
    mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IACC = 2'd1,
        DACC = 2'd2
    } state_e;

    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam logic [1:0] RAM_ERROR  = 2'd3;
    localparam logic [2:0] STARVE_CAP = 3'(STARVE_MAX);

    state_e     state_q;
    state_e     state_d;
    logic [2:0] streak_q;
    logic [2:0] streak_d;

    logic d_req_s;
    logic term_s;
    logic ram_err_s;

    // Request/RAM-status decode shared by both grant states.
    always_comb begin
        d_req_s   = bus.dREN | bus.dWEN;
        term_s    = (bus.ramstate == RAM_ACCESS) || (bus.ramstate == RAM_ERROR);
        ram_err_s = (bus.ramstate == RAM_ERROR);
    end

    // State and starvation streak registers; reset drops any access in flight.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q  <= IDLE;
            streak_q <= 3'd0;
        end else begin
            state_q  <= state_d;
            streak_q <= streak_d;
        end
    end

    // Arbitration, RAM drive, wait/load generation and streak bookkeeping.
    always_comb begin
        state_d      = state_q;
        streak_d     = streak_q;
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.ramaddr  = 32'h0000_0000;
        bus.ramstore = 32'h0000_0000;
        bus.iwait    = bus.iREN;
        bus.dwait    = d_req_s;
        bus.err      = 1'b0;
        bus.iload    = bus.ramload;
        bus.dload    = bus.ramload;

        case (state_q)
            IDLE: begin
                // A starved fetch beats a pending data request.
                if (d_req_s && !(bus.iREN && (streak_q == STARVE_CAP))) begin
                    state_d = DACC;
                end else if (bus.iREN) begin
                    state_d = IACC;
                end else begin
                    state_d = IDLE;
                end
            end
            IACC: begin
                bus.ramREN  = 1'b1;
                bus.ramaddr = bus.iaddr;
                if (!bus.iREN) begin
                    // Requester walked away: abandon quietly.
                    state_d = IDLE;
                end else if (term_s) begin
                    bus.iwait = 1'b0;
                    state_d   = IDLE;
                    streak_d  = 3'd0;
                    if (ram_err_s) begin
                        bus.err   = 1'b1;
                        bus.iload = ERR_WORD;
                    end else begin
                        bus.err   = 1'b0;
                    end
                end else begin
                    state_d = IACC;
                end
            end
            DACC: begin
                bus.ramWEN   = bus.dWEN;
                bus.ramREN   = bus.dREN & ~bus.dWEN;
                bus.ramaddr  = bus.daddr;
                bus.ramstore = bus.dstore;
                if (!d_req_s) begin
                    state_d = IDLE;
                end else if (term_s) begin
                    bus.dwait = 1'b0;
                    state_d   = IDLE;
                    // Streak only counts data wins that kept a fetch waiting.
                    if (!bus.iREN) begin
                        streak_d = 3'd0;
                    end else if (streak_q != STARVE_CAP) begin
                        streak_d = streak_q + 3'd1;
                    end else begin
                        streak_d = streak_q;
                    end
                    if (ram_err_s) begin
                        bus.err   = 1'b1;
                        bus.dload = ERR_WORD;
                    end else begin
                        bus.err   = 1'b0;
                    end
                end else begin
                    state_d = DACC;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios followed by a
// randomized run, all checked every cycle against a behavioural owner/streak
// model of the arbitration rules.
module tb_mem_arbiter;
    localparam int          STARVE = 4;
    localparam logic [31:0] ERRW   = 32'hBAD1BAD1;

    logic CLK  = 1'b0;
    logic nRST = 1'b0;
    always #5 CLK = ~CLK;

    mem_arbiter_if bus();

    mem_arbiter #(.STARVE_MAX(STARVE), .ERR_WORD(ERRW)) dut (
        .CLK (CLK),
        .nRST(nRST),
        .bus (bus.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: who owns the RAM (0 none, 1 fetch, 2 data) and how many
    // data wins in a row have kept a fetch waiting.
    int   m_owner  = 0;
    int   m_streak = 0;
    logic s_iren, s_dreq, s_term;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                         input logic [31:0] da, input logic [31:0] ds,
                         input logic [31:0] rl, input logic [1:0] rs);
        bus.iREN = ir; bus.iaddr = ia; bus.dREN = dr; bus.dWEN = dw;
        bus.daddr = da; bus.dstore = ds; bus.ramload = rl; bus.ramstate = rs;
    endtask

    // Let inputs settle, then compare every output with the model.
    task automatic eval_cycle();
        logic        dq, term, er;
        logic        e_rren, e_rwen, e_iw, e_dw, e_err;
        logic [31:0] e_addr, e_store, e_il, e_dl;
        #1;
        dq   = bus.dREN | bus.dWEN;
        term = (bus.ramstate == 2'd2) || (bus.ramstate == 2'd3);
        er   = (bus.ramstate == 2'd3);
        e_rren = 1'b0; e_rwen = 1'b0; e_addr = 32'h0; e_store = 32'h0;
        e_iw = bus.iREN; e_dw = dq; e_err = 1'b0;
        e_il = bus.ramload; e_dl = bus.ramload;
        if (m_owner == 1) begin
            e_rren = 1'b1; e_addr = bus.iaddr;
            if (bus.iREN && term) begin
                e_iw = 1'b0;
                if (er) begin e_err = 1'b1; e_il = ERRW; end
            end
        end else if (m_owner == 2) begin
            e_rwen = bus.dWEN; e_rren = bus.dREN & ~bus.dWEN;
            e_addr = bus.daddr; e_store = bus.dstore;
            if (dq && term) begin
                e_dw = 1'b0;
                if (er) begin e_err = 1'b1; e_dl = ERRW; end
            end
        end
        check_val("ramREN",   32'(bus.ramREN), 32'(e_rren));
        check_val("ramWEN",   32'(bus.ramWEN), 32'(e_rwen));
        check_val("ramaddr",  bus.ramaddr,     e_addr);
        check_val("ramstore", bus.ramstore,    e_store);
        check_val("iwait",    32'(bus.iwait),  32'(e_iw));
        check_val("dwait",    32'(bus.dwait),  32'(e_dw));
        check_val("err",      32'(bus.err),    32'(e_err));
        check_val("iload",    bus.iload,       e_il);
        check_val("dload",    bus.dload,       e_dl);
        s_iren = bus.iREN; s_dreq = dq; s_term = term;
    endtask

    // Clock edge: advance the model, then return to the falling edge.
    task automatic advance();
        @(posedge CLK);
        if (!nRST) begin
            m_owner = 0; m_streak = 0;
        end else if (m_owner == 0) begin
            if (s_dreq && !(s_iren && m_streak == STARVE)) m_owner = 2;
            else if (s_iren) m_owner = 1;
        end else if (m_owner == 1) begin
            if (!s_iren) m_owner = 0;
            else if (s_term) begin m_owner = 0; m_streak = 0; end
        end else begin
            if (!s_dreq) m_owner = 0;
            else if (s_term) begin
                m_owner  = 0;
                m_streak = s_iren ? ((m_streak < STARVE) ? m_streak + 1 : STARVE) : 0;
            end
        end
        @(negedge CLK);
    endtask

    task automatic go_idle();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 2'd0);
        eval_cycle(); advance();
        eval_cycle(); advance();
    endtask

    int   dcount, icount;
    logic ir, dr, dw;

    initial begin
        drive(1'b1, 32'h10, 1'b1, 1'b0, 32'h20, 32'h30, 32'h44, 2'd2);
        @(negedge CLK);
        // Reset state: IDLE outputs with waits following requests.
        eval_cycle();
        check_val("rst_ramREN", 32'(bus.ramREN), 32'd0);
        check_val("rst_iwait",  32'(bus.iwait),  32'd1);
        advance();
        nRST = 1'b1;
        go_idle();

        // Single fetch completing on its first granted cycle.
        drive(1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 2'd0);
        eval_cycle();
        check_val("i_idle_wait", 32'(bus.iwait), 32'd1);
        advance();
        drive(1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, 32'h8C220004, 2'd2);
        eval_cycle();
        check_val("i_ramaddr", bus.ramaddr,     32'h40);
        check_val("i_iwait",   32'(bus.iwait),  32'd0);
        check_val("i_iload",   bus.iload,       32'h8C220004);
        advance();
        eval_cycle();
        check_val("i_back_idle", 32'(bus.ramREN), 32'd0);
        advance();
        go_idle();

        // Fetch and write together: write first, then fetch.
        drive(1'b1, 32'h80, 1'b0, 1'b1, 32'h100, 32'hDEADBEEF, 32'h0, 2'd1);
        eval_cycle(); advance();
        eval_cycle();
        check_val("w_ramWEN",   32'(bus.ramWEN), 32'd1);
        check_val("w_ramstore", bus.ramstore,    32'hDEADBEEF);
        check_val("w_iwait",    32'(bus.iwait),  32'd1);
        advance();
        drive(1'b1, 32'h80, 1'b0, 1'b1, 32'h100, 32'hDEADBEEF, 32'h0, 2'd2);
        eval_cycle();
        check_val("w_dwait", 32'(bus.dwait), 32'd0);
        advance();
        drive(1'b1, 32'h80, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 2'd1);
        eval_cycle(); advance();
        eval_cycle();
        check_val("w_then_iacc", bus.ramaddr, 32'h80);
        advance();
        drive(1'b1, 32'h80, 1'b0, 1'b0, 32'h0, 32'h0, 32'h1234, 2'd2);
        eval_cycle(); advance();
        go_idle();

        // Starvation: continuous data reads with a waiting fetch.
        drive(1'b1, 32'hC0, 1'b1, 1'b0, 32'h200, 32'h0, 32'h55, 2'd2);
        dcount = 0; icount = 0;
        for (int k = 0; k < 40 && icount == 0; k++) begin
            eval_cycle();
            if (bus.dwait == 1'b0) dcount++;
            if (bus.iwait == 1'b0) icount++;
            advance();
        end
        check_val("starve_dcomp", 32'(dcount), 32'd4);
        check_val("starve_icomp", 32'(icount), 32'd1);
        eval_cycle(); advance();
        eval_cycle();
        check_val("starve_reset_d", 32'(bus.dwait), 32'd0);
        advance();
        go_idle();

        // RAM error on a data read.
        drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h300, 32'h0, 32'h777, 2'd0);
        eval_cycle(); advance();
        drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h300, 32'h0, 32'h777, 2'd3);
        eval_cycle();
        check_val("e_dload", bus.dload,     32'hBAD1BAD1);
        check_val("e_err",   32'(bus.err),  32'd1);
        advance();
        eval_cycle();
        check_val("e_err_once", 32'(bus.err), 32'd0);
        advance();
        go_idle();

        // Three BUSY cycles then ACCESS.
        drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h400, 32'h0, 32'h9, 2'd1);
        eval_cycle(); advance();
        for (int k = 0; k < 3; k++) begin
            eval_cycle();
            check_val("b_dwait",   32'(bus.dwait), 32'd1);
            check_val("b_ramaddr", bus.ramaddr,    32'h400);
            advance();
        end
        drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h400, 32'h0, 32'h9, 2'd2);
        eval_cycle();
        check_val("b_done", 32'(bus.dwait), 32'd0);
        advance();
        go_idle();

        // Reset pulse in the middle of a BUSY data access.
        drive(1'b1, 32'h0, 1'b1, 1'b0, 32'h500, 32'h0, 32'h0, 2'd1);
        eval_cycle(); advance();
        eval_cycle();
        nRST = 1'b0;
        m_owner = 0; m_streak = 0;
        eval_cycle();
        check_val("r_ramREN", 32'(bus.ramREN), 32'd0);
        check_val("r_dwait",  32'(bus.dwait),  32'd1);
        advance();
        nRST = 1'b1;
        eval_cycle(); advance();
        go_idle();

        // Randomized traffic against the model.
        ir = 1'b0; dr = 1'b0; dw = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            int r;
            if ($urandom_range(7) == 0) ir = ($urandom_range(3) != 0);
            if ($urandom_range(7) == 0) begin dr = 1'($urandom_range(1)); dw = 1'($urandom_range(1)); end
            r = $urandom_range(9);
            drive(ir, $urandom, dr, dw, $urandom, $urandom, $urandom,
                  (r < 2) ? 2'd0 : (r < 5) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3);
            eval_cycle(); advance();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter STARVE_MAX, default 4, number of consecutive data completions with iREN pending before the instruction request is given priority.
REQ-002 Parameter ERR_WORD, default 32'hBAD1BAD1, load value returned on a RAM error.
REQ-003 CLK  in  1  clock, rising-edge active.
REQ-004 nRST  in  1  reset, asynchronous, active-low.
REQ-005 iREN  in  1  instruction fetch request from the datapath/icache.
REQ-006 iaddr  in  32  instruction address.
REQ-007 iwait  out  1  instruction stall; low for exactly the completing cycle.
REQ-008 iload  out  32  instruction fetch data.
REQ-009 dREN, dWEN  in  1 each  data read request and data write request.
REQ-010 daddr, dstore  in  32 each  data address and data store value.
REQ-011 dwait  out  1  data stall; low for exactly the completing cycle.
REQ-012 dload  out  32  data load value.
REQ-013 ramREN, ramWEN  out  1 each  RAM read strobe and RAM write strobe.
REQ-014 ramaddr, ramstore  out  32 each  RAM address and RAM store value.
REQ-015 ramload  in  32  RAM read data.
REQ-016 ramstate  in  2  RAM status: FREE=0, BUSY=1, ACCESS=2, ERROR=3.
REQ-017 err  out  1  one-cycle pulse on the erroring cycle of a RAM access.

Function
REQ-018 FSM SHALL have states IDLE, IACC and DACC, with the state held in a register.
REQ-019 In IDLE, when dREN|dWEN is high, the FSM SHALL go to DACC, except when iREN is high and the streak counter equals STARVE_MAX.
- In that exception case the FSM goes to IACC.
- Otherwise, when only iREN is high, the FSM goes to IACC.
- With no request pending, the FSM stays in IDLE.
REQ-020 In IDLE, all ram* outputs SHALL be 0, and iwait SHALL equal iREN and dwait SHALL equal dREN|dWEN.
REQ-021 In IACC, the block SHALL drive ramREN=1, ramWEN=0, ramaddr=iaddr and ramstore=0.
REQ-022 In DACC, the block SHALL drive ramWEN=dWEN, ramREN=dREN&~dWEN (write wins), ramaddr=daddr and ramstore=dstore.
REQ-023 Completion SHALL occur when the FSM is in IACC/DACC and ramstate==ACCESS.
- The granted requester's wait goes low for that cycle only.
- The FSM returns to IDLE on the next edge.
REQ-024 When the FSM is in IACC/DACC and ramstate==ERROR, the access SHALL terminate as a completion, with the granted load forced to ERR_WORD, err=1 for that cycle, and a return to IDLE.
REQ-025 While ramstate is FREE or BUSY, the FSM SHALL hold its grant state and keep the granted wait high.
REQ-026 A non-granted requester's wait SHALL stay high while that requester is asserting its request.
REQ-027 iload and dload SHALL pass ramload through combinationally, except when REQ-024 forces ERR_WORD.
REQ-028 If the granted requester deasserts its request mid-access, the FSM SHALL return to IDLE on the next edge with no completion, no err pulse and no streak update.
REQ-029 Streak counter, 3 bits, saturating at STARVE_MAX:
- increments on a data completion while iREN is high;
- clears on any instruction completion;
- clears on a data completion while iREN is low.
REQ-030 Latency SHALL be at least one cycle: a request first seen in IDLE on cycle N is granted on cycle N+1, and can complete no earlier than cycle N+1.
REQ-031 A new request present on the cycle of a return to IDLE SHALL be arbitrated in IDLE on the following cycle, so that the arbiter has no back-to-back grant without passing through IDLE.
REQ-032 The grant SHALL never change while the FSM is in IACC or DACC, regardless of new requests.

Reset
REQ-033 On nRST low, asynchronously: FSM=IDLE and streak=0.
- Output values follow IDLE: ram* outputs 0, err=0, and waits equal to their request inputs.
REQ-034 A reset asserted mid-access SHALL abandon the access with no completion signalled, and the arbiter SHALL restart from IDLE after reset.

Verification
REQ-035 iREN=1, iaddr=0x40, ramstate ACCESS on the first IACC cycle, ramload=0x8C220004 -> ramREN=1, ramaddr=0x40 in cycle N+1; iwait=0 and iload=0x8C220004 in that cycle; IDLE in cycle N+2.
REQ-036 iREN and dWEN both high, daddr=0x100, dstore=0xDEADBEEF -> DACC with ramWEN=1, ramaddr=0x100, ramstore=0xDEADBEEF; iwait stays 1 until the data access completes, then IACC follows.
REQ-037 iREN held high while dREN is re-asserted continuously -> exactly 4 data completions, then one IACC completion, then streak=0.
REQ-038 In DACC with ramstate=ERROR -> dwait=0, dload=0xBAD1BAD1, err=1 for exactly one cycle; IDLE next cycle.
REQ-039 ramstate=BUSY for 3 cycles then ACCESS -> wait high for 3 cycles then low for 1; ram outputs stable throughout.
REQ-040 nRST pulsed low during DACC with BUSY -> immediate IDLE, ram* outputs 0, streak=0, and no dwait low pulse.
